// File: rtl/seq_det_pkg.sv
// Shared definitions for the round-robin scheduler and its serial pattern detector.
package seq_det_pkg;

   // One-hot controller states; any other encoding is treated as illegal.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'b001,
      ST_SHIFT = 3'b010,
      ST_DRAIN = 3'b100
   } state_e;

   // Default pattern: MSB is the first bit received.
   localparam int              DEF_PAT_W   = 5;
   localparam logic [4:0]      DEF_PATTERN = 5'b10010;

   // Ceiling log2 used to size ids and counters at elaboration time.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((1 << r) < value) r++;
      end
      return r;
   endfunction

endpackage

// File: rtl/seq_det_sched_if.sv
// Requester-side bus of the scheduler: request/word inputs, grant and result outputs.
interface seq_det_sched_if
   import seq_det_pkg::*;
#(
   parameter int NREQ   = 4,
   parameter int WORD_W = 16
);
   localparam int ID_W  = clog2(NREQ);
   localparam int CNT_W = clog2(WORD_W + 1);

   logic [NREQ-1:0]        req;
   logic [NREQ*WORD_W-1:0] word;
   logic [NREQ-1:0]        gnt;
   logic                   busy;
   logic                   done;
   logic [ID_W-1:0]        done_id;
   logic [CNT_W-1:0]       match_cnt;

   // Requester side drives requests and words, sees grants and results.
   modport master (
      output req, word,
      input  gnt, busy, done, done_id, match_cnt
   );

   // Scheduler side.
   modport slave (
      input  req, word,
      output gnt, busy, done, done_id, match_cnt
   );
endinterface

// File: rtl/seq_window_det.sv
// Serial pattern detector: PAT_W-bit window plus fill counter, so a match
// only fires once the window holds PAT_W bits of the current word.
module seq_window_det
   import seq_det_pkg::*;
#(
   parameter int               PAT_W   = DEF_PAT_W,
   parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic bit_vld,
   input  logic bit_in,
   output logic match
);
   localparam int FILL_W = clog2(PAT_W + 1);

   logic [PAT_W-1:0]  window_q, window_d;
   logic [FILL_W-1:0] fill_q,   fill_d;
   logic              match_q,  match_d;

   // Next window/fill/match; clr wins over a shifted bit so words never mix.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      window_d = window_q;
      fill_d   = fill_q;
      match_d  = 1'b0;
      if (clr) begin
         window_d = '0;
         fill_d   = '0;
      end else if (bit_vld) begin
         window_d = {window_q[PAT_W-2:0], bit_in};
         if (fill_q != FILL_W'(PAT_W)) fill_d = fill_q + FILL_W'(1);
         match_d = (fill_d >= FILL_W'(PAT_W)) && (window_d == PATTERN);
      end
   end

   // Detector state registers, cleared asynchronously.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         // NOTE: state flops use non-blocking assignments so all of them update from pre-edge values.
         window_q <= '0;
         fill_q   <= '0;
         match_q  <= 1'b0;
      end else begin
         window_q <= window_d;
         fill_q   <= fill_d;
         match_q  <= match_d;
      end
   end

   assign match = match_q;
endmodule

// File: rtl/seq_det_sched.sv
// Round-robin scheduler sharing one serial pattern detector among NREQ
// word requesters; reports per-word match counts tagged with the requester id.
module seq_det_sched
   import seq_det_pkg::*;
#(
   parameter int               NREQ    = 4,
   parameter int               WORD_W  = 16,
   parameter int               PAT_W   = DEF_PAT_W,
   parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN
) (
   input logic             clk,
   input logic             rst,
   seq_det_sched_if.slave  bus
);
   localparam int ID_W  = clog2(NREQ);
   localparam int CNT_W = clog2(WORD_W + 1);

   state_e            state_q,     state_d;
   logic [ID_W-1:0]   ptr_q,       ptr_d;
   logic [WORD_W-1:0] sr_q,        sr_d;
   logic [CNT_W-1:0]  bit_cnt_q,   bit_cnt_d;
   logic [CNT_W-1:0]  acc_q,       acc_d;
   logic [NREQ-1:0]   gnt_q,       gnt_d;
   logic              busy_q,      busy_d;
   logic              done_q,      done_d;
   logic [ID_W-1:0]   done_id_q,   done_id_d;
   logic [CNT_W-1:0]  match_cnt_q, match_cnt_d;

   logic              found;
   logic [ID_W-1:0]   winner;
   logic              det_clr;
   logic              det_vld;
   logic              det_match;

   seq_window_det #(
      .PAT_W   (PAT_W),
      .PATTERN (PATTERN)
   ) u_det (
      .clk     (clk),
      .rst     (rst),
      .clr     (det_clr),
      .bit_vld (det_vld),
      .bit_in  (sr_q[WORD_W-1]),
      .match   (det_match)
   );

   // Round-robin pick: first set req bit starting just after the last winner.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      for (int k = 1; k <= NREQ; k++) begin
         int idx;
         idx = (int'(ptr_q) + k) % NREQ;
         if (!found && bus.req[idx]) begin
            found  = 1'b1;
            winner = ID_W'(idx);
         end
      end
   end

   // Controller: grant and load in IDLE, serialise in SHIFT, publish in DRAIN.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      sr_d        = sr_q;
      bit_cnt_d   = bit_cnt_q;
      acc_d       = acc_q;
      gnt_d       = '0;
      busy_d      = busy_q;
      done_d      = 1'b0;
      done_id_d   = done_id_q;
      match_cnt_d = match_cnt_q;
      det_clr     = 1'b0;
      det_vld     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (found) begin
               sr_d      = bus.word[int'(winner)*WORD_W +: WORD_W];
               bit_cnt_d = CNT_W'(WORD_W);
               gnt_d     = NREQ'(1) << winner;
               ptr_d     = winner;
               acc_d     = '0;
               det_clr   = 1'b1;
               busy_d    = 1'b1;
               state_d   = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            det_vld   = 1'b1;
            sr_d      = {sr_q[WORD_W-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q - CNT_W'(1);
            acc_d     = acc_q + CNT_W'(det_match);
            if (bit_cnt_q == CNT_W'(1)) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            // The match from the final bit is only visible now.
            acc_d       = acc_q + CNT_W'(det_match);
            match_cnt_d = acc_d;
            done_id_d   = ptr_q;
            done_d      = 1'b1;
            busy_d      = 1'b0;
            state_d     = ST_IDLE;
         end
         default: begin
            // Corrupted state: recover silently without a done pulse.
            busy_d  = 1'b0;
            det_clr = 1'b1;
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers; ptr resets so requester 0 has first priority.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         ptr_q       <= ID_W'(NREQ - 1);
         sr_q        <= '0;
         bit_cnt_q   <= '0;
         acc_q       <= '0;
         gnt_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         done_id_q   <= '0;
         match_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         sr_q        <= sr_d;
         bit_cnt_q   <= bit_cnt_d;
         acc_q       <= acc_d;
         gnt_q       <= gnt_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         done_id_q   <= done_id_d;
         match_cnt_q <= match_cnt_d;
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.done_id   = done_id_q;
   assign bus.match_cnt = match_cnt_q;
endmodule

// File: tb/tb_seq_det_sched.sv
// Directed bench for seq_det_sched: hand-computed match counts, grant order and timing.
module tb_seq_det_sched;
   localparam int NREQ   = 4;
   localparam int WORD_W = 16;

   logic clk = 1'b0;
   logic rst;
   int   cyc_cnt = 0;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   seq_det_sched_if #(.NREQ(NREQ), .WORD_W(WORD_W)) bus ();

   seq_det_sched #(.NREQ(NREQ), .WORD_W(WORD_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Waits (bounded) for any gnt; returns it and the cycle stamp.
   task automatic wait_gnt(input string tag, output logic [NREQ-1:0] g, output int t);
      g = '0;
      t = 0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (bus.gnt != '0) begin
            g = bus.gnt;
            t = cyc_cnt;
            break;
         end
      end
      check({tag, "_gnt_seen"}, 32'(g != '0), 1);
   endtask

   // Counts cycles (bounded) from the gnt cycle to the done cycle.
   task automatic wait_done(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.done && n < 60);
   endtask

   task automatic serve(input int id, input logic [WORD_W-1:0] w, input int exp_cnt, input string tag);
      logic [NREQ-1:0] g;
      int t, n;
      bus.word[id*WORD_W +: WORD_W] = w;
      bus.req[id] = 1'b1;
      wait_gnt(tag, g, t);
      check({tag, "_gnt"}, g, 32'(1 << id));
      check({tag, "_busy_hi"}, bus.busy, 1);
      bus.req[id] = 1'b0;
      wait_done(n);
      check({tag, "_latency"}, n, 17);
      check({tag, "_done_id"}, bus.done_id, id);
      check({tag, "_match_cnt"}, bus.match_cnt, exp_cnt);
      check({tag, "_busy_lo"}, bus.busy, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [NREQ-1:0] g;
      int t, t_prev, n, seen;
      int exp3 [4] = '{1, 1, 0, 4};

      rst = 1'b0;
      bus.req  = '0;
      bus.word = '0;
      repeat (2) @(negedge clk);
      check("rst_gnt", bus.gnt, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_done_id", bus.done_id, 0);
      check("rst_match_cnt", bus.match_cnt, 0);
      @(negedge clk);
      rst = 1'b1;

      // Overlapping matches, and done is a single-cycle pulse.
      serve(0, 16'b1001001001001000, 4, "t1");
      @(negedge clk);
      check("t1_done_pulse", bus.done, 0);

      // No matches for all-zero and all-one words.
      serve(1, 16'h0000, 0, "t2a");
      serve(1, 16'hFFFF, 0, "t2b");

      // Pattern completes on the last bit; counted in DRAIN.
      serve(1, 16'b0000000000010010, 1, "t6");

      // Pointer wrap: lone req3, then req0 and req3 together -> 0 then 3.
      serve(3, 16'h9000, 1, "t4a");
      bus.word[0*WORD_W +: WORD_W] = 16'h0012;
      bus.word[3*WORD_W +: WORD_W] = 16'h0000;
      bus.req = 4'b1001;
      wait_gnt("t4b", g, t);
      check("t4b_gnt", g, 4'b0001);
      bus.req[0] = 1'b0;
      wait_done(n);
      check("t4b_done_id", bus.done_id, 0);
      check("t4b_match_cnt", bus.match_cnt, 1);
      wait_gnt("t4c", g, t);
      check("t4c_gnt", g, 4'b1000);
      bus.req[3] = 1'b0;
      wait_done(n);
      check("t4c_done_id", bus.done_id, 3);
      check("t4c_match_cnt", bus.match_cnt, 0);

      // All four requesting at reset release: served 0..3, 18 cycles apart.
      @(negedge clk);
      rst = 1'b0;
      bus.word = {16'h9248, 16'h0000, 16'h9000, 16'h0012};
      bus.req  = 4'b1111;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      t_prev = 0;
      for (int i = 0; i < NREQ; i++) begin
         wait_gnt($sformatf("t3_%0d", i), g, t);
         check($sformatf("t3_gnt_%0d", i), g, 32'(1 << i));
         if (i > 0) check($sformatf("t3_spacing_%0d", i), t - t_prev, 18);
         t_prev = t;
         bus.req[i] = 1'b0;
         wait_done(n);
         check($sformatf("t3_latency_%0d", i), n, 17);
         check($sformatf("t3_done_id_%0d", i), bus.done_id, i);
         check($sformatf("t3_match_cnt_%0d", i), bus.match_cnt, exp3[i]);
      end

      // Reset in the 8th SHIFT cycle: outputs clear at once, no done follows.
      bus.word[2*WORD_W +: WORD_W] = 16'h9248;
      bus.req[2] = 1'b1;
      wait_gnt("t5", g, t);
      bus.req[2] = 1'b0;
      repeat (7) @(negedge clk);
      rst = 1'b0;
      #1;
      check("t5_rst_gnt", bus.gnt, 0);
      check("t5_rst_busy", bus.busy, 0);
      check("t5_rst_done", bus.done, 0);
      check("t5_rst_done_id", bus.done_id, 0);
      check("t5_rst_match_cnt", bus.match_cnt, 0);
      @(negedge clk);
      rst = 1'b1;
      seen = 0;
      repeat (25) begin
         @(negedge clk);
         if (bus.done) seen++;
      end
      check("t5_no_done", seen, 0);
      serve(2, 16'b1001000000000000, 1, "t5b");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
